uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the received word width.
REQ-002 The block SHALL have parameter ADDR_BITS, default 4, giving FIFO depth 2**ADDR_BITS (16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with the following ports:
  sys_clk  input  1  system clock; all state changes on the rising edge
  rst  input  1  synchronous, active-high reset
  rx_done_tick  input  1  frame-complete level from the receiver; may stay high for several sys_clk cycles
  rx_dout  input  DATA_BITS  received word; stable while rx_done_tick is high
  rd_en  input  1  consumer read request
  rd_data  output  DATA_BITS  registered read word
  rd_valid  output  1  rd_data holds a newly read word this cycle
  empty  output  1  FIFO holds 0 words
  full  output  1  FIFO holds 2**ADDR_BITS words
  count  output  ADDR_BITS+1  number of words held
  overrun  output  1  sticky flag: a word was dropped because the FIFO was full
  overrun_clr  input  1  clears overrun

Function
REQ-004 The block SHALL register rx_done_tick into done_q each cycle and derive wr_req = rx_done_tick AND NOT done_q, giving exactly one write request per frame regardless of tick length.
REQ-005 On wr_req with full=0, the block SHALL write rx_dout to mem[wr_ptr] and increment wr_ptr (mod depth) on the same edge.
REQ-006 On wr_req with full=1 and no accepted read that cycle, the block SHALL drop the word, leave pointers and count unchanged, and set overrun=1 on the next edge.
REQ-007 On rd_en with empty=0, the block SHALL load rd_data<=mem[rd_ptr], increment rd_ptr (mod depth), and drive rd_valid=1 for exactly the following cycle (1-cycle read latency).
REQ-008 When rd_en is asserted with empty=1, the block SHALL ignore it, leave rd_data unchanged, and drive rd_valid=0.
REQ-009 Simultaneous accepted read and write SHALL leave count unchanged; when full=1, the read frees the slot and the write SHALL be accepted without overrun.
REQ-010 Simultaneous wr_req and rd_en with empty=1 SHALL accept the write only; the read SHALL be ignored.
REQ-011 count SHALL be a registered value equal to (words written - words read) with no wrap error at depth; full=(count==2**ADDR_BITS) and empty=(count==0), both registered or decoded from registered count, with no combinational path from inputs.
REQ-012 Pointers SHALL be ADDR_BITS wide and wrap from 2**ADDR_BITS-1 to 0.
REQ-013 overrun SHALL remain set until overrun_clr=1; if overrun_clr and a new overrun event occur in the same cycle, set SHALL win.
REQ-014 Data order SHALL be strictly first-in, first-out.

Reset
REQ-015 While rst=1 at a sys_clk edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, rd_valid=0, rd_data=0, done_q=0.
REQ-016 Reset mid-operation SHALL discard all stored words; mem contents need not be cleared.
REQ-017 An rx_done_tick already high when rst deasserts SHALL produce one write on the first non-reset edge (done_q=0 after reset).

Structure
REQ-018 DATA_BITS and FIFO depth defaults SHALL live as constants in the shared uart_pkg package, also used by the UART RX/TX blocks.
REQ-019 The storage array SHALL be a sub-module uart_fifo_mem (one write port, one registered read port); pointer, count, flag and edge-detect logic SHALL stay in uart_rx_fifo.

Verification
REQ-020 Reset, then one rx_done_tick pulse held 5 cycles with rx_dout=8'hA5 -> exactly one write; count=1; empty=0; rd_en pulse -> rd_valid=1 next cycle with rd_data=8'hA5, count=0.
REQ-021 Write 16 words 0x00..0x0F, then a 17th (0xFF) -> full=1, count=16, overrun=1; read all 16 -> data 0x00..0x0F in order; 0xFF never appears.
REQ-022 Full FIFO, wr_req and rd_en in the same cycle -> count stays 16, overrun stays 0, oldest word out, new word is read last.
REQ-023 Empty FIFO, wr_req (0x3C) and rd_en in the same cycle -> rd_valid=0; count=1; next rd_en returns 0x3C.
REQ-024 Overrun set, then overrun_clr asserted in the same cycle as another dropped write -> overrun remains 1; overrun_clr alone on the next cycle -> overrun=0.
REQ-025 Assert rst with count=7 -> next cycle count=0, empty=1, rd_valid=0; wr_ptr/rd_ptr wrap verified by 40 write/read pairs with correct data.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART word width and receive FIFO depth constants
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_FIFO_ADDR_BITS = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - FIFO storage: one write port, one registered read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int ADDR_BITS = UART_FIFO_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read returns the pre-write contents when both ports hit the same slot,
  // which is what lets a full FIFO read its oldest word while refilling it.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO with frame-edge write detect and sticky overrun
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int ADDR_BITS = UART_FIFO_ADDR_BITS
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_done_tick,
  input  logic [DATA_BITS-1:0] rx_dout,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   count,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic                 done_q;
  logic                 wr_req;
  logic                 rd_acc;
  logic                 wr_acc;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign wr_req = rx_done_tick & ~done_q;
  assign rd_acc = rd_en & ~empty;
  // A same-cycle read frees a slot, so a write into a full FIFO still lands.
  assign wr_acc = wr_req & (~full | rd_acc);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      done_q   <= rx_done_tick;
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && !wr_acc) overrun <= 1'b1;
      else if (overrun_clr)  overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk    (sys_clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(rx_dout),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo with a queue model
module tb_uart_rx_fifo;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       prev_tick = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  uart_rx_fifo dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .rx_done_tick(rx_done_tick),
    .rx_dout     (rx_dout),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // One clock with the given inputs; the model follows the frame/FIFO rules.
  task automatic cycle(input logic tick, input logic [7:0] dout, input logic rd, input logic clr);
    logic wr, can_rd, was_full;
    rst = 1'b0; rx_done_tick = tick; rx_dout = dout; rd_en = rd; overrun_clr = clr;
    wr       = tick && !prev_tick;
    was_full = (q.size() == 16);
    can_rd   = rd && (q.size() > 0);
    m_valid  = can_rd;
    if (can_rd) m_data = q.pop_front();
    if (wr && (!was_full || can_rd)) q.push_back(dout);
    if (wr && was_full && !can_rd) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    prev_tick = tick;
    @(posedge sys_clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; rd_en = 1'(($urandom) & 1); overrun_clr = 1'b0;
    repeat (n) begin @(posedge sys_clk); #1; end
    q.delete(); prev_tick = 1'b0; m_ovr = 1'b0; m_valid = 1'b0; m_data = 8'h00;
  endtask

  task automatic test_reset;
    rx_done_tick = 1'b0;
    do_reset(2);
    checks++;
    if ({count, empty, full, overrun, rd_valid, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b ovr=%b valid=%b data=%h, need 0 1 0 0 0 00",
               count, empty, full, overrun, rd_valid, rd_data);
    end
  endtask

  task automatic test_single_tick;
    repeat (5) cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL long_tick_one_write: count=%0d empty=%b, need 1 0", count, empty);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 5'd0) begin
      errors++; $display("FAIL single_read: valid=%b data=%h count=%0d, need 1 a5 0", rd_valid, rd_data, count);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL valid_one_cycle: valid=%b, need 0", rd_valid);
    end
  endtask

  task automatic test_fill_overrun;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1) begin
      errors++; $display("FAIL fill_overrun: full=%b count=%0d ovr=%b, need 1 16 1", full, count, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++; $display("FAIL fifo_order[%0d]: valid=%b data=%h, need 1 %h", i, rd_valid, rd_data, 8'(i));
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h0F || empty !== 1'b1) begin
      errors++; $display("FAIL read_empty: valid=%b data=%h empty=%b, need 0 0f 1", rd_valid, rd_data, empty);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_full_rw;
    logic [7:0] vals[16];
    logic [7:0] nv;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'($urandom);
      cycle(1'b1, vals[i], 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    nv = 8'($urandom);
    cycle(1'b1, nv, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd16 || overrun !== 1'b0 || rd_valid !== 1'b1 || rd_data !== vals[0]) begin
      errors++;
      $display("FAIL full_rw: count=%0d ovr=%b valid=%b data=%h, need 16 0 1 %h", count, overrun, rd_valid, rd_data, vals[0]);
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (rd_data !== ((i == 16) ? nv : vals[i])) begin
        errors++; $display("FAIL full_rw_drain[%0d]: data=%h, need %h", i, rd_data, (i == 16) ? nv : vals[i]);
      end
    end
  endtask

  task automatic test_empty_rw;
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL empty_rw: valid=%b count=%0d, need 0 1", rd_valid, count);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      errors++; $display("FAIL empty_rw_read: valid=%b data=%h, need 1 3c", rd_valid, rd_data);
    end
  endtask

  task automatic test_overrun_clr;
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set_wins: ovr=%b, need 1", overrun);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear: ovr=%b, need 0", overrun);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL pre_reset_count: count=%0d, need 7", count);
    end
    rd_en = 1'b1;
    do_reset(1);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: count=%0d empty=%b valid=%b, need 0 1 0", count, empty, rd_valid);
    end
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      cycle(1'b1, d, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== d) begin
        errors++; $display("FAIL wrap_pair[%0d]: valid=%b data=%h, need 1 %h", i, rd_valid, rd_data, d);
      end
    end
  endtask

  task automatic test_tick_at_reset_release;
    rx_done_tick = 1'b1;
    do_reset(2);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd1) begin
      errors++; $display("FAIL tick_at_release: count=%0d, need 1", count);
    end
  endtask

  task automatic test_random;
    logic tick;
    tick = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      cycle(tick, 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
      checks++;
      if ({count, empty, full, overrun, rd_valid, rd_data} !==
          {5'(q.size()), q.size() == 0, q.size() == 16, m_ovr, m_valid, m_data}) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d e=%b f=%b ovr=%b v=%b d=%h, need %0d %b %b %b %b %h", n,
                 count, empty, full, overrun, rd_valid, rd_data,
                 q.size(), q.size() == 0, q.size() == 16, m_ovr, m_valid, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tick();
    test_fill_overrun();
    test_full_rw();
    test_empty_rw();
    test_overrun_clr();
    test_reset_mid();
    test_tick_at_reset_release();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
